// File: rtl/mste_speed_ctrl.sv
// CPU clock-enable sequencer: 8/16 MHz phase enables from a 32 MHz clock, slow-bus stretching, cache enable/flush.
// Speed changes land only on ST bus slot boundaries; the CPU is stalled via missing phi pulses, not via handshake.
module mste_speed_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_16mhz,
    input  logic       enable_cache,
    input  logic       cpu_as_n,
    input  logic       bus_slow,
    output logic       cpu_phi1,
    output logic       cpu_phi2,
    output logic       cpu16,
    output logic       cache_en,
    output logic       cache_flush,
    output logic [1:0] st_slot
);

    typedef enum logic [1:0] {
        ST_S8   = 2'd0,
        ST_S16  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SLOW = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   boundary;
    logic   slow_access;
    logic   mode_flip;
    logic   enable_cache_q;

    // The edge that takes st_slot from 3 to 0 is the only safe point to switch decode.
    assign boundary    = (st_slot == 2'd3);
    assign slow_access = ~cpu_as_n & bus_slow;

    always_comb begin
        next_state = state;
        case (state)
            ST_S8: begin
                if (boundary && cpu_as_n && enable_16mhz)
                    next_state = ST_S16;
            end
            ST_S16: begin
                if (slow_access)
                    next_state = boundary ? ST_SLOW : ST_WAIT;
                else if (boundary && cpu_as_n && !enable_16mhz)
                    next_state = ST_S8;
            end
            ST_WAIT: begin
                if (boundary)
                    next_state = ST_SLOW;
            end
            ST_SLOW: begin
                if (boundary && cpu_as_n)
                    next_state = enable_16mhz ? ST_S16 : ST_S8;
            end
            default: next_state = ST_S8;
        endcase
    end

    always_comb begin
        mode_flip = 1'b0;
        if ((state == ST_S8   && next_state == ST_S16) ||
            (state == ST_S16  && next_state == ST_S8)  ||
            (state == ST_SLOW && next_state == ST_S8))
            mode_flip = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_slot        <= 2'd0;
            state          <= ST_S8;
            cache_en       <= 1'b0;
            cache_flush    <= 1'b0;
            enable_cache_q <= 1'b0;
        end else begin
            st_slot        <= st_slot + 2'd1;
            state          <= next_state;
            cache_en       <= enable_cache & (next_state != ST_S8);
            cache_flush    <= (enable_cache_q & ~enable_cache) | mode_flip;
            enable_cache_q <= enable_cache;
        end
    end

    // SLOW reuses the 8 MHz decode so stretched accesses stay aligned to the ST bus slot.
    always_comb begin
        cpu_phi1 = 1'b0;
        cpu_phi2 = 1'b0;
        if (!reset) begin
            case (state)
                ST_S8, ST_SLOW: begin
                    cpu_phi1 = (st_slot == 2'd0);
                    cpu_phi2 = (st_slot == 2'd2);
                end
                ST_S16: begin
                    cpu_phi1 = ~st_slot[0];
                    cpu_phi2 = st_slot[0];
                end
                default: begin
                    cpu_phi1 = 1'b0;
                    cpu_phi2 = 1'b0;
                end
            endcase
        end
    end

    assign cpu16 = (state != ST_S8);

endmodule

// File: tb/tb_mste_speed_ctrl.sv
// Bench for mste_speed_ctrl: per-cycle vector table plus hand-written corner sequences, checked through a scoreboard queue.
module tb_mste_speed_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_16mhz;
    logic       enable_cache;
    logic       cpu_as_n;
    logic       bus_slow;
    logic       cpu_phi1;
    logic       cpu_phi2;
    logic       cpu16;
    logic       cache_en;
    logic       cache_flush;
    logic [1:0] st_slot;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       rst, e16, ec, as_n, slow;
        logic       p1, p2, c16, ce, fl;
        logic [1:0] slot;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    mste_speed_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable_16mhz (enable_16mhz),
        .enable_cache (enable_cache),
        .cpu_as_n     (cpu_as_n),
        .bus_slow     (bus_slow),
        .cpu_phi1     (cpu_phi1),
        .cpu_phi2     (cpu_phi2),
        .cpu16        (cpu16),
        .cache_en     (cache_en),
        .cache_flush  (cache_flush),
        .st_slot      (st_slot)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, e16, ec, as_n, slow,
                                input logic p1, p2, c16, ce, fl,
                                input logic [1:0] slot);
        vec_t v;
        v.rst = rst; v.e16 = e16; v.ec = ec; v.as_n = as_n; v.slow = slow;
        v.p1 = p1; v.p2 = p2; v.c16 = c16; v.ce = ce; v.fl = fl; v.slot = slot;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue its expectation, and compare on the falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        reset        = v.rst;
        enable_16mhz = v.e16;
        enable_cache = v.ec;
        cpu_as_n     = v.as_n;
        bus_slow     = v.slow;
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard cycle %0d got empty expected entry", cyc);
        end else begin
            e = sb.pop_front();
            chk("st_slot",     st_slot,            e.slot);
            chk("cpu_phi1",    {1'b0, cpu_phi1},    {1'b0, e.p1});
            chk("cpu_phi2",    {1'b0, cpu_phi2},    {1'b0, e.p2});
            chk("cpu16",       {1'b0, cpu16},       {1'b0, e.c16});
            chk("cache_en",    {1'b0, cache_en},    {1'b0, e.ce});
            chk("cache_flush", {1'b0, cache_flush}, {1'b0, e.fl});
        end
        cyc++;
    endtask

    initial begin
        reset        = 1'b1;
        enable_16mhz = 1'b0;
        enable_cache = 1'b0;
        cpu_as_n     = 1'b1;
        bus_slow     = 1'b0;

        // Reset cycle, then 8 MHz decode from release: phi1 at slot 0, phi2 at slot 2.
        tbl.push_back(mk(1,0,0,1,0, 0,0,0,0,0, 2'd0));
        for (int c = 0; c < 13; c++) begin
            logic [1:0] s;
            s = 2'(c % 4);
            tbl.push_back(mk(0,0,0,1,0, (s == 2'd0), (s == 2'd2), 0,0,0, s));
        end
        // Request 16 MHz (and cache) at slot 1: switch at next slot 0 with one flush.
        tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0, 2'd1));
        tbl.push_back(mk(0,1,1,1,0, 0,1,0,0,0, 2'd2));
        tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0, 2'd3));
        tbl.push_back(mk(0,1,1,1,0, 1,0,1,1,1, 2'd0));
        tbl.push_back(mk(0,1,1,1,0, 0,1,1,1,0, 2'd1));
        tbl.push_back(mk(0,1,1,1,0, 1,0,1,1,0, 2'd2));
        tbl.push_back(mk(0,1,1,1,0, 0,1,1,1,0, 2'd3));
        // Slow access starting in slot 0 cycle: WAIT over slots 1-3, SLOW decode, back to S16 without flush.
        tbl.push_back(mk(0,1,1,0,1, 1,0,1,1,0, 2'd0));
        tbl.push_back(mk(0,1,1,0,1, 0,0,1,1,0, 2'd1));
        tbl.push_back(mk(0,1,1,0,1, 0,0,1,1,0, 2'd2));
        tbl.push_back(mk(0,1,1,0,1, 0,0,1,1,0, 2'd3));
        tbl.push_back(mk(0,1,1,0,1, 1,0,1,1,0, 2'd0));
        tbl.push_back(mk(0,1,1,0,1, 0,0,1,1,0, 2'd1));
        tbl.push_back(mk(0,1,1,1,0, 0,1,1,1,0, 2'd2));
        tbl.push_back(mk(0,1,1,1,0, 0,0,1,1,0, 2'd3));
        tbl.push_back(mk(0,1,1,1,0, 1,0,1,1,0, 2'd0));
        tbl.push_back(mk(0,1,1,1,0, 0,1,1,1,0, 2'd1));
        // Drop to 8 MHz while AS is active: held across a boundary, then switch with flush.
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,0, 2'd2));
        tbl.push_back(mk(0,0,1,0,0, 0,1,1,1,0, 2'd3));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,0, 2'd0));
        tbl.push_back(mk(0,0,1,1,0, 0,1,1,1,0, 2'd1));
        tbl.push_back(mk(0,0,1,1,0, 1,0,1,1,0, 2'd2));
        tbl.push_back(mk(0,0,1,1,0, 0,1,1,1,0, 2'd3));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,0,1, 2'd0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        // Back to S16, then cache disable coinciding with the S16->S8 change: a single flush.
        step(mk(0,1,1,1,0, 0,0,0,0,0, 2'd1));
        step(mk(0,1,1,1,0, 0,1,0,0,0, 2'd2));
        step(mk(0,1,1,1,0, 0,0,0,0,0, 2'd3));
        step(mk(0,1,1,1,0, 1,0,1,1,1, 2'd0));
        step(mk(0,1,1,1,0, 0,1,1,1,0, 2'd1));
        step(mk(0,1,1,1,0, 1,0,1,1,0, 2'd2));
        step(mk(0,0,0,1,0, 0,1,1,1,0, 2'd3));
        step(mk(0,0,0,1,0, 1,0,0,0,1, 2'd0));

        // Into WAIT, then one-clk reset at slot 2 with AS still asserted.
        step(mk(0,1,0,1,0, 0,0,0,0,0, 2'd1));
        step(mk(0,1,0,1,0, 0,1,0,0,0, 2'd2));
        step(mk(0,1,0,1,0, 0,0,0,0,0, 2'd3));
        step(mk(0,1,0,0,1, 1,0,1,0,1, 2'd0));
        step(mk(0,1,0,0,1, 0,0,1,0,0, 2'd1));
        step(mk(1,1,0,0,1, 0,0,1,0,0, 2'd2));
        step(mk(0,0,0,0,1, 1,0,0,0,0, 2'd0));
        step(mk(0,0,0,1,0, 0,0,0,0,0, 2'd1));
        step(mk(0,0,0,1,0, 0,1,0,0,0, 2'd2));

        // Cache enable pulse in S8: cache_en stays 0, falling edge still flushes.
        step(mk(0,0,1,1,0, 0,0,0,0,0, 2'd3));
        step(mk(0,0,0,1,0, 1,0,0,0,0, 2'd0));
        step(mk(0,0,0,1,0, 0,0,0,0,1, 2'd1));
        step(mk(0,0,0,1,0, 0,1,0,0,0, 2'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
